// File: rtl/mul_scheduler_pkg.sv
// Shared definitions for the two-requester shift-add multiplier.
// Holds the default operand width, the FSM state encodings and the
// round-robin winner selection used by the scheduler.
package mul_scheduler_pkg;

  localparam int MUL_DEFAULT_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Returns the index of the requester that wins this arbitration round.
  // A lone requester always wins; with both requesting, the pointer decides.
  function automatic logic pickWinner(input logic req0, input logic req1, input logic ptr);
    logic win;
    if (req0 && req1) begin
      win = ptr;
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Sequential signed multiplier datapath (one shift-add iteration per step).
// Ports:
//   Clock, Reset      : clock and synchronous active-high reset
//   iLoad             : capture iA/iB, clear accumulator and iteration count
//   iStep             : perform one iteration at the current count
//   iA, iB            : signed operands, WIDTH bits
//   oLast             : current iteration is the final one (count == ITER-1)
//   oProduct          : sign-corrected product including the current step's
//                       addend, meaningful when iStep and oLast are both high
module mul_shift_add_core
  import mul_scheduler_pkg::*;
#(
  parameter int WIDTH = MUL_DEFAULT_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iLoad,
  input  logic               iStep,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  output logic               oLast,
  output logic [2*WIDTH-1:0] oProduct
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  // Magnitudes carry one extra bit so that |-2^(WIDTH-1)| is representable.
  logic [WIDTH:0]  magAR;
  logic [WIDTH:0]  magBR;
  logic            negR;
  logic [PW-1:0]   accR;
  logic [CW-1:0]   countR;

  logic [WIDTH:0]  extAS;
  logic [WIDTH:0]  extBS;
  logic [WIDTH:0]  magAS;
  logic [WIDTH:0]  magBS;
  logic [WIDTH:0]  shiftedBS;
  logic            bitS;
  logic [PW-1:0]   magAWideS;
  logic [PW-1:0]   addendS;
  logic [PW-1:0]   nextAccS;

  assign extAS = {iA[WIDTH-1], iA};
  assign extBS = {iB[WIDTH-1], iB};

  // Operand magnitudes and the per-iteration accumulator update.
  always_comb begin
    magAS     = extAS;
    magBS     = extBS;
    if (iA[WIDTH-1]) begin
      magAS = -extAS;
    end else begin
      magAS = extAS;
    end
    if (iB[WIDTH-1]) begin
      magBS = -extBS;
    end else begin
      magBS = extBS;
    end
    // Shifting instead of indexing makes counts beyond the multiplier width read as zero.
    shiftedBS = magBR >> countR;
    bitS      = shiftedBS[0];
    magAWideS = {{(PW-WIDTH-1){1'b0}}, magAR};
    addendS   = magAWideS << countR;
    if (bitS) begin
      nextAccS = accR + addendS;
    end else begin
      nextAccS = accR;
    end
  end

  assign oLast    = (countR == CW'(ITER - 1));
  assign oProduct = negR ? -nextAccS : nextAccS;

  // Operand capture, accumulation and iteration counting.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      magAR  <= {(WIDTH+1){1'b0}};
      magBR  <= {(WIDTH+1){1'b0}};
      negR   <= 1'b0;
      accR   <= {PW{1'b0}};
      countR <= {CW{1'b0}};
    end else if (iLoad) begin
      magAR  <= magAS;
      magBR  <= magBS;
      negR   <= iA[WIDTH-1] ^ iB[WIDTH-1];
      accR   <= {PW{1'b0}};
      countR <= {CW{1'b0}};
    end else if (iStep) begin
      accR <= nextAccS;
      if (!oLast) begin
        countR <= countR + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Two-requester front end for the shift-add multiplier.
// Round-robin arbitration in IDLE, ITER iterations in RUN, one DONE cycle.
// Ports:
//   Clock, Reset        : clock and synchronous active-high reset
//   iReq0, iA0, iB0     : requester 0 request and signed operands
//   iReq1, iA1, iB1     : requester 1 request and signed operands
//   oGnt0, oGnt1        : one-cycle grant pulse (first RUN cycle)
//   oDone0, oDone1      : one-cycle completion pulse (the DONE cycle)
//   oResult             : signed 2*WIDTH product of the last operation
//   oResultId           : requester index of the last completed operation
//   oBusy               : state is not IDLE
module mul_scheduler
  import mul_scheduler_pkg::*;
#(
  parameter int WIDTH = MUL_DEFAULT_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iReq0,
  input  logic [WIDTH-1:0]   iA0,
  input  logic [WIDTH-1:0]   iB0,
  input  logic               iReq1,
  input  logic [WIDTH-1:0]   iA1,
  input  logic [WIDTH-1:0]   iB1,
  output logic               oGnt0,
  output logic               oGnt1,
  output logic               oDone0,
  output logic               oDone1,
  output logic [2*WIDTH-1:0] oResult,
  output logic               oResultId,
  output logic               oBusy
);

  logic [1:0]         stateR;
  logic [1:0]         nextStateS;
  logic               ptrR;
  logic               winnerR;

  logic               winnerS;
  logic               captureS;
  logic               stepS;
  logic               finishS;
  logic               lastS;
  logic [WIDTH-1:0]   opAS;
  logic [WIDTH-1:0]   opBS;
  logic [2*WIDTH-1:0] productS;

  assign winnerS  = pickWinner(iReq0, iReq1, ptrR);
  assign captureS = (stateR == ST_IDLE) && (iReq0 || iReq1);
  assign stepS    = (stateR == ST_RUN);
  assign finishS  = stepS && lastS;
  assign opAS     = winnerS ? iA1 : iA0;
  assign opBS     = winnerS ? iB1 : iB0;
  assign oBusy    = (stateR != ST_IDLE);

  mul_shift_add_core #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) uCore (
    .Clock    (Clock),
    .Reset    (Reset),
    .iLoad    (captureS),
    .iStep    (stepS),
    .iA       (opAS),
    .iB       (opBS),
    .oLast    (lastS),
    .oProduct (productS)
  );

  // Next-state selection for the IDLE/RUN/DONE sequence.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      ST_IDLE: begin
        if (captureS) begin
          nextStateS = ST_RUN;
        end else begin
          nextStateS = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (lastS) begin
          nextStateS = ST_DONE;
        end else begin
          nextStateS = ST_RUN;
        end
      end
      ST_DONE: nextStateS = ST_IDLE;
      default: nextStateS = ST_IDLE;
    endcase
  end

  // State, winner and round-robin pointer registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateR  <= ST_IDLE;
      ptrR    <= 1'b0;
      winnerR <= 1'b0;
    end else begin
      stateR <= nextStateS;
      if (captureS) begin
        winnerR <= winnerS;
        // The loser gets priority next time, even when it was not requesting.
        ptrR    <= ~winnerS;
      end
    end
  end

  // Registered grant/done pulses and the held result.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oGnt0     <= 1'b0;
      oGnt1     <= 1'b0;
      oDone0    <= 1'b0;
      oDone1    <= 1'b0;
      oResult   <= {(2*WIDTH){1'b0}};
      oResultId <= 1'b0;
    end else begin
      oGnt0  <= captureS && !winnerS;
      oGnt1  <= captureS && winnerS;
      oDone0 <= finishS && !winnerR;
      oDone1 <= finishS && winnerR;
      if (finishS) begin
        oResult   <= productS;
        oResultId <= winnerR;
      end
    end
  end

endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler: stimulus pushes expected grants and
// results into queues, a negedge monitor pops and compares them.
module tb_mul_scheduler;

  logic        Clock;
  logic        Reset;
  logic        iReq0;
  logic [15:0] iA0;
  logic [15:0] iB0;
  logic        iReq1;
  logic [15:0] iA1;
  logic [15:0] iB1;
  logic        oGnt0;
  logic        oGnt1;
  logic        oDone0;
  logic        oDone1;
  logic [31:0] oResult;
  logic        oResultId;
  logic        oBusy;

  typedef struct {
    logic        id;
    logic [31:0] res;
  } expT;

  expT  expQ[$];
  logic gntQ[$];

  int   nChecks = 0;
  int   nFails = 0;
  int   cyc = 0;
  int   lastGntCyc = 0;
  bit   havePrevGnt = 1'b0;
  bit   spacingOn = 1'b0;

  mul_scheduler dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iReq0     (iReq0),
    .iA0       (iA0),
    .iB0       (iB0),
    .iReq1     (iReq1),
    .iA1       (iA1),
    .iB1       (iB1),
    .oGnt0     (oGnt0),
    .oGnt1     (oGnt1),
    .oDone0    (oDone0),
    .oDone1    (oDone1),
    .oResult   (oResult),
    .oResultId (oResultId),
    .oBusy     (oBusy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: grants and completions are checked against the queues.
  always @(negedge Clock) begin
    if (oGnt0 && oGnt1) begin
      chk("dual_gnt", 32'd1, 32'd0);
    end else if (oGnt0 || oGnt1) begin
      if (gntQ.size() == 0) begin
        chk("unexpected_gnt", 32'd0, 32'd1);
      end else begin
        logic e;
        e = gntQ.pop_front();
        chk("gnt_id", {31'd0, oGnt1}, {31'd0, e});
        if (spacingOn && havePrevGnt) chk("capture_spacing", cyc - lastGntCyc, 32'd18);
      end
      lastGntCyc = cyc;
      havePrevGnt = 1'b1;
    end
    if (oDone0 && oDone1) begin
      chk("dual_done", 32'd1, 32'd0);
    end else if (oDone0 || oDone1) begin
      if (expQ.size() == 0) begin
        chk("unexpected_done", 32'd0, 32'd1);
      end else begin
        expT e;
        e = expQ.pop_front();
        chk("done_id", {31'd0, oDone1}, {31'd0, e.id});
        chk("result_id", {31'd0, oResultId}, {31'd0, e.id});
        chk("result", oResult, e.res);
        chk("latency", cyc - lastGntCyc, 32'd16);
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (oBusy && n < 60) begin
      tick();
      n++;
    end
    chk("idle_reached", {31'd0, oBusy}, 32'd0);
  endtask

  task automatic waitGnt(input logic id);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      tick();
      n++;
      got = id ? oGnt1 : oGnt0;
    end
    chk("gnt_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic runOp(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] expRes, output int waitCycles);
    int   n;
    logic got;
    gntQ.push_back(id);
    expQ.push_back('{id: id, res: expRes});
    if (id) begin
      iA1 = a; iB1 = b; iReq1 = 1'b1;
    end else begin
      iA0 = a; iB0 = b; iReq0 = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      tick();
      n++;
      got = id ? oGnt1 : oGnt0;
    end
    chk("gnt_seen", {31'd0, got}, 32'd1);
    waitCycles = n;
    iReq0 = 1'b0;
    iReq1 = 1'b0;
    waitIdle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int g;
    int n;
    Reset = 1'b1;
    iReq0 = 1'b0; iA0 = 16'd0; iB0 = 16'd0;
    iReq1 = 1'b0; iA1 = 16'd0; iB1 = 16'd0;
    doReset();

    // Reset state
    chk("rst_busy", {31'd0, oBusy}, 32'd0);
    chk("rst_result", oResult, 32'd0);
    chk("rst_result_id", {31'd0, oResultId}, 32'd0);
    chk("rst_gnt", {30'd0, oGnt1, oGnt0}, 32'd0);
    chk("rst_done", {30'd0, oDone1, oDone0}, 32'd0);

    // 3*5 right after reset: grant on the first edge
    runOp(1'b0, 16'd3, 16'd5, 32'h0000_000F, w);
    chk("first_gnt_cycle", w, 32'd1);

    // -7*6 on requester 1
    runOp(1'b1, 16'hFFF9, 16'd6, 32'hFFFF_FFD6, w);
    // Most negative squared
    runOp(1'b0, 16'h8000, 16'h8000, 32'h4000_0000, w);
    // Zero operand still runs the full length
    runOp(1'b0, 16'd0, 16'hFFFF, 32'h0000_0000, w);
    // Mixed sign on requester 1
    runOp(1'b1, 16'd100, 16'hFFFD, 32'hFFFF_FED4, w);

    // Both requesters held high from reset: alternate grants 18 cycles apart
    Reset = 1'b1;
    iA0 = 16'd2; iB0 = 16'd3; iA1 = 16'd4; iB1 = 16'd5;
    iReq0 = 1'b1; iReq1 = 1'b1;
    gntQ.push_back(1'b0); gntQ.push_back(1'b1); gntQ.push_back(1'b0); gntQ.push_back(1'b1);
    expQ.push_back('{id: 1'b0, res: 32'd6});
    expQ.push_back('{id: 1'b1, res: 32'd20});
    expQ.push_back('{id: 1'b0, res: 32'd6});
    expQ.push_back('{id: 1'b1, res: 32'd20});
    havePrevGnt = 1'b0;
    spacingOn = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    g = 0;
    n = 0;
    while (g < 4 && n < 200) begin
      tick();
      n++;
      if (oGnt0 || oGnt1) g++;
    end
    chk("grants_seen", g, 32'd4);
    iReq0 = 1'b0;
    iReq1 = 1'b0;
    waitIdle();
    spacingOn = 1'b0;

    // Reset in the 8th RUN cycle aborts the operation
    gntQ.push_back(1'b0);
    iA0 = 16'd9; iB0 = 16'd9; iReq0 = 1'b1;
    waitGnt(1'b0);
    iReq0 = 1'b0;
    repeat (7) tick();
    chk("run_busy", {31'd0, oBusy}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort_busy", {31'd0, oBusy}, 32'd0);
    chk("abort_result", oResult, 32'd0);
    chk("abort_result_id", {31'd0, oResultId}, 32'd0);
    repeat (25) tick();
    runOp(1'b1, 16'd100, 16'hFFFD, 32'hFFFF_FED4, w);

    // Requester 0 raised and dropped while busy is never served
    gntQ.push_back(1'b1);
    expQ.push_back('{id: 1'b1, res: 32'd49});
    iA1 = 16'd7; iB1 = 16'd7; iReq1 = 1'b1;
    waitGnt(1'b1);
    iReq1 = 1'b0;
    repeat (2) tick();
    iA0 = 16'd5; iB0 = 16'd5; iReq0 = 1'b1;
    repeat (5) tick();
    iReq0 = 1'b0;
    waitIdle();
    repeat (20) tick();
    chk("held_result", oResult, 32'd49);
    chk("held_result_id", {31'd0, oResultId}, 32'd1);
    chk("gnt_queue_empty", gntQ.size(), 32'd0);
    chk("exp_queue_empty", expQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
